mux_sel_sequencer: RTL
======================

# mux_sel_sequencer

Upstream driver and loopback checker for the 4:1 select mux. It accepts one data word through a valid/ready handshake and presents it on the mux data inputs. It then steps the mux select through every index, sampling the mux output at each step and emitting it as a serial bit stream. After the last index it reassembles the captured bits into a word and compares that word against the one it loaded, giving a per-word mismatch flag and a sticky error.

## Interface
- SEL_W, 2, select width; word width W = 2**SEL_W (4 at default)
- MSB_FIRST, 0, 0: select steps 0→W-1; 1: select steps W-1→0
- HOLD, 1, cycles each select value is held before sampling; legal range 1..256

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  word offered
- in_data  in  W  word to serialize
- in_ready  out  1  high only in IDLE; a transfer occurs when in_valid && in_ready
- mux_in  out  W  latched word, drives mux data inputs
- mux_sel  out  SEL_W  drives mux select
- mux_out  in  1  mux result, combinational from mux_in/mux_sel
- ser_bit  out  1  sampled mux output
- ser_valid  out  1  one-cycle pulse qualifying ser_bit
- cap_data  out  W  reassembled word, bit [i] = mux_out sampled while mux_sel==i
- cap_valid  out  1  one-cycle pulse, cap_data/mismatch valid
- mismatch  out  1  cap_data != mux_in, qualified by cap_valid
- err  out  1  sticky OR of every mismatch; cleared only by reset

## Operation
- States: IDLE, RUN, DONE. START = 0 if MSB_FIRST=0, else W-1. LAST = the other end.
- IDLE: in_ready=1. On transfer, mux_in<=in_data, mux_sel<=START, hold_cnt<=0, next state RUN.
- RUN: hold_cnt increments each cycle.
  - When hold_cnt==HOLD-1: sample mux_out, set cap_data[mux_sel]<=mux_out, ser_bit<=mux_out, ser_valid<=1, hold_cnt<=0.
  - If mux_sel==LAST, go to DONE and set mux_sel<=START. Otherwise step mux_sel by ±1.
- DONE, one cycle: cap_valid=1; mismatch=(cap_data!=mux_in); err|=mismatch. Next state IDLE.
- mux_in holds its value until the next transfer. mux_sel holds START in IDLE and DONE.
- cap_data is cleared to 0 on each transfer, so a stale bit cannot satisfy the compare.
- in_valid and in_data are ignored outside IDLE. in_ready=0 in RUN and DONE.
- mux_sel stepping never wraps mid-word. The state leaves RUN at LAST.
- Every output except in_ready is registered. in_ready is decoded from state.

## Timing
- Reset values (async assert, sync release): state IDLE, in_ready=1, mux_in=0, mux_sel=START, ser_bit=0, ser_valid=0, cap_data=0, cap_valid=0, mismatch=0, err=0, hold_cnt=0.
- Transfer in cycle T → mux_in and mux_sel=START visible in cycle T+1.
- The k-th sample (k=1..W) is taken at the end of cycle T+k*HOLD. ser_valid is high in cycle T+k*HOLD+1.
- The DONE cycle is T+W*HOLD+1. cap_valid coincides with the last ser_valid.
- IDLE returns at T+W*HOLD+2. Minimum word period is W*HOLD+2 cycles.
- Reset asserted mid-RUN or mid-DONE aborts immediately: no cap_valid, and err clears. The first transfer after release behaves as from cold.
- The mux path is combinational within one cycle, so mux_out must be stable by the end of each sample cycle.

## Test plan
- HOLD=1, LSB-first, ideal mux model (out=in[sel]), in_data=1000 at T:
  - mux_sel 0,1,2,3 in T+1..T+4.
  - ser_bit 0,0,0,1 in T+2..T+5.
  - cap_valid at T+5 with cap_data=1000, mismatch=0.
- MSB_FIRST=1, in_data=1001:
  - mux_sel 3,2,1,0.
  - ser_bit 1,0,0,1.
  - cap_data=1001, mismatch=0.
- HOLD=3, in_data=0110:
  - Each mux_sel held 3 cycles.
  - ser_valid in T+4, T+7, T+10, T+13.
  - cap_valid at T+13, in_ready back high at T+14.
- Mux model stuck-at-0 when sel=3, in_data=1000:
  - cap_data=0000, mismatch=1, err=1.
  - Next word 0001 with a healthy mux gives mismatch=0 while err stays 1.
- in_valid held high with in_data changing every cycle:
  - Transfers only at 6-cycle spacing (HOLD=1).
  - Each captured word equals in_data at its transfer cycle.
- rst_n pulsed low at T+3 of a run:
  - All outputs take reset values within the low phase, and no cap_valid is produced.
  - After release, in_data=1001 completes normally with cap_data=1001.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// Loads one word, walks the 4:1 mux select over it, serializes the samples,
// then compares the reassembled word with the loaded one.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    word handshake (ready only while idle)
//   in_data              word to serialize
//   mux_in, mux_sel      drive the mux under test
//   mux_out              mux result, sampled at the end of each hold period
//   ser_bit/ser_valid    sampled bit stream
//   cap_data/cap_valid   reassembled word and its qualifier
//   mismatch, err        per-word compare result and sticky error
module mux_sel_sequencer #(
  parameter int SEL_W     = 2,
  parameter int MSB_FIRST = 0,
  parameter int HOLD      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [(1<<SEL_W)-1:0] in_data,
  output logic               in_ready,
  output logic [(1<<SEL_W)-1:0] mux_in,
  output logic [SEL_W-1:0]   mux_sel,
  input  logic               mux_out,
  output logic               ser_bit,
  output logic               ser_valid,
  output logic [(1<<SEL_W)-1:0] cap_data,
  output logic               cap_valid,
  output logic               mismatch,
  output logic               err
);

  localparam int W    = 1 << SEL_W;
  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [SEL_W-1:0] START =
    (MSB_FIRST != 0) ? SEL_W'(W - 1) : '0;
  localparam logic [SEL_W-1:0] LAST =
    (MSB_FIRST != 0) ? '0 : SEL_W'(W - 1);
  localparam logic [HC_W-1:0] HOLD_M1 = HC_W'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      mux_in_q, mux_in_d;
  logic [SEL_W-1:0]  mux_sel_q, mux_sel_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic              ser_bit_q, ser_bit_d;
  logic              ser_valid_q, ser_valid_d;
  logic [W-1:0]      cap_q, cap_d;
  logic              cap_valid_q, cap_valid_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    mux_in_d    = mux_in_q;
    mux_sel_d   = mux_sel_q;
    hold_d      = hold_q;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = 1'b0;
    cap_d       = cap_q;
    cap_valid_d = 1'b0;
    mis_d       = mis_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mux_in_d  = in_data;
          mux_sel_d = START;
          hold_d    = '0;
          cap_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (hold_q == HOLD_M1) begin
          hold_d            = '0;
          cap_d[mux_sel_q]  = mux_out;
          ser_bit_d         = mux_out;
          ser_valid_d       = 1'b1;
          if (mux_sel_q == LAST) begin
            // Compare includes the bit captured on this same edge.
            state_d     = S_DONE;
            mux_sel_d   = START;
            cap_valid_d = 1'b1;
            mis_d       = (cap_d != mux_in_q);
            err_d       = err_q | mis_d;
          end else if (MSB_FIRST != 0) begin
            mux_sel_d = mux_sel_q - SEL_W'(1);
          end else begin
            mux_sel_d = mux_sel_q + SEL_W'(1);
          end
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mux_in_q    <= '0;
      mux_sel_q   <= START;
      hold_q      <= '0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      cap_q       <= '0;
      cap_valid_q <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_in_q    <= mux_in_d;
      mux_sel_q   <= mux_sel_d;
      hold_q      <= hold_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      cap_q       <= cap_d;
      cap_valid_q <= cap_valid_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mux_in    = mux_in_q;
  assign mux_sel   = mux_sel_q;
  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign cap_data  = cap_q;
  assign cap_valid = cap_valid_q;
  assign mismatch  = mis_q;
  assign err       = err_q;

endmodule
